// File: rtl/dmem_arbiter.sv
// Data-memory arbiter sharing one single-port memory between the CPU MEM stage
// and a loader/debug port, with a starvation limit that forces a loader grant.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [63:0] ld_addr,
  input  logic [63:0] ld_wdata,
  output logic        ld_ack,
  output logic [63:0] ld_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RESP = 2'd1,
    LD_RESP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  starve_cnt;
  logic [2:0]  starve_next;
  logic [63:0] cpu_hold;
  logic [63:0] ld_hold;
  logic        cpu_req;
  logic        ld_grant;
  logic        cpu_grant;

  assign cpu_req = cpu_read | cpu_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      cpu_hold   <= 64'd0;
      ld_hold    <= 64'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      if (state == CPU_RESP) begin
        cpu_hold <= mem_rdata;
      end
      if (state == LD_RESP) begin
        ld_hold <= mem_rdata;
      end
    end
  end

  // All outputs are forced low while reset is held, even though the inputs
  // may still be asserting requests.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    ld_grant    = 1'b0;
    cpu_grant   = 1'b0;
    mem_addr    = 64'd0;
    mem_wdata   = 64'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cpu_stall   = 1'b0;
    ld_ack      = 1'b0;
    cpu_rdata   = cpu_hold;
    ld_rdata    = ld_hold;

    if (!reset) begin
      case (state)
        IDLE: begin
          ld_grant  = ld_req && (!cpu_req || (starve_cnt == 3'(STARVE_MAX)));
          cpu_grant = !ld_grant && cpu_req;

          if (ld_grant || !ld_req) begin
            starve_next = 3'd0;
          end else if (starve_cnt != 3'(STARVE_MAX)) begin
            starve_next = starve_cnt + 3'd1;
          end

          if (ld_grant) begin
            mem_addr  = ld_addr;
            cpu_stall = cpu_req;
            if (ld_we) begin
              mem_write = 1'b1;
              mem_wdata = ld_wdata;
              ld_ack    = 1'b1;
            end else begin
              mem_read   = 1'b1;
              state_next = LD_RESP;
            end
          end else if (cpu_grant) begin
            mem_addr = cpu_addr;
            // A simultaneous read+write request is serviced as a plain store.
            if (cpu_write) begin
              mem_write = 1'b1;
              mem_wdata = cpu_wdata;
            end else begin
              mem_read   = 1'b1;
              cpu_stall  = 1'b1;
              state_next = CPU_RESP;
            end
          end
        end

        CPU_RESP: begin
          cpu_rdata  = mem_rdata;
          state_next = IDLE;
        end

        LD_RESP: begin
          ld_ack     = 1'b1;
          ld_rdata   = mem_rdata;
          cpu_stall  = cpu_req;
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled mid-cycle.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpuRead;
  logic        cpuWrite;
  logic [63:0] cpuAddr;
  logic [63:0] cpuWdata;
  logic [63:0] cpuRdata;
  logic        cpuStall;
  logic        ldReq;
  logic        ldWe;
  logic [63:0] ldAddr;
  logic [63:0] ldWdata;
  logic        ldAck;
  logic [63:0] ldRdata;
  logic [63:0] memAddr;
  logic [63:0] memWdata;
  logic        memRead;
  logic        memWrite;
  logic [63:0] memRdata;

  int checkCount;
  int errorCount;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_read  (cpuRead),
    .cpu_write (cpuWrite),
    .cpu_addr  (cpuAddr),
    .cpu_wdata (cpuWdata),
    .cpu_rdata (cpuRdata),
    .cpu_stall (cpuStall),
    .ld_req    (ldReq),
    .ld_we     (ldWe),
    .ld_addr   (ldAddr),
    .ld_wdata  (ldWdata),
    .ld_ack    (ldAck),
    .ld_rdata  (ldRdata),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_read  (memRead),
    .mem_write (memWrite),
    .mem_rdata (memRdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw,
                               input logic [63:0] ca, input logic [63:0] cd,
                               input logic lr, input logic lw,
                               input logic [63:0] la, input logic [63:0] ld,
                               input logic [63:0] mr);
    cpuRead  = cr;
    cpuWrite = cw;
    cpuAddr  = ca;
    cpuWdata = cd;
    ldReq    = lr;
    ldWe     = lw;
    ldAddr   = la;
    ldWdata  = ld;
    memRdata = mr;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0, 64'h0);
    #3;
    checkOutput("rst_mem_read", memRead, 1'b0);
    checkOutput("rst_mem_write", memWrite, 1'b0);
    checkOutput("rst_mem_addr", memAddr, 64'h0);
    checkOutput("rst_cpu_stall", cpuStall, 1'b0);
    checkOutput("rst_ld_ack", ldAck, 1'b0);
    checkOutput("rst_cpu_rdata", cpuRdata, 64'h0);
    checkOutput("rst_ld_rdata", ldRdata, 64'h0);

    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    nextCycle();
    reset = 1'b0;
    #3;
    checkOutput("idle_mem_read", memRead, 1'b0);
    checkOutput("idle_mem_write", memWrite, 1'b0);

    // CPU store with no loader traffic
    nextCycle();
    applyStimulus(1'b0, 1'b1, 64'h20, 64'h5, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #3;
    checkOutput("st_mem_write", memWrite, 1'b1);
    checkOutput("st_mem_read", memRead, 1'b0);
    checkOutput("st_mem_addr", memAddr, 64'h20);
    checkOutput("st_mem_wdata", memWdata, 64'h5);
    checkOutput("st_cpu_stall", cpuStall, 1'b0);

    // CPU load, data arrives the following cycle
    nextCycle();
    applyStimulus(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #3;
    checkOutput("ld0_mem_read", memRead, 1'b1);
    checkOutput("ld0_mem_addr", memAddr, 64'h10);
    checkOutput("ld0_cpu_stall", cpuStall, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 64'h10, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'hDEAD);
    #3;
    checkOutput("ld1_cpu_rdata", cpuRdata, 64'hDEAD);
    checkOutput("ld1_cpu_stall", cpuStall, 1'b0);
    checkOutput("ld1_mem_read", memRead, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1234);
    #3;
    checkOutput("ld2_cpu_rdata", cpuRdata, 64'hDEAD);
    checkOutput("ld2_mem_read", memRead, 1'b0);
    nextCycle();
    #3;
    checkOutput("ld3_cpu_rdata", cpuRdata, 64'hDEAD);

    // Simultaneous read and write behaves as a store
    nextCycle();
    applyStimulus(1'b1, 1'b1, 64'h30, 64'h99, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #3;
    checkOutput("rw_mem_write", memWrite, 1'b1);
    checkOutput("rw_mem_read", memRead, 1'b0);
    checkOutput("rw_mem_wdata", memWdata, 64'h99);
    checkOutput("rw_cpu_stall", cpuStall, 1'b0);

    // Loader write starved by back-to-back CPU stores
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 64'h50 + 64'(i), 64'h1, 1'b1, 1'b1, 64'h40, 64'hAB, 64'h0);
      #3;
      checkOutput($sformatf("starve%0d_ld_ack", i), ldAck, 1'b0);
      checkOutput($sformatf("starve%0d_mem_addr", i), memAddr, 64'h50 + 64'(i));
      checkOutput($sformatf("starve%0d_cpu_stall", i), cpuStall, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 64'h60, 64'h1, 1'b1, 1'b1, 64'h40, 64'hAB, 64'h0);
    #3;
    checkOutput("force_ld_ack", ldAck, 1'b1);
    checkOutput("force_mem_write", memWrite, 1'b1);
    checkOutput("force_mem_addr", memAddr, 64'h40);
    checkOutput("force_mem_wdata", memWdata, 64'hAB);
    checkOutput("force_cpu_stall", cpuStall, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 64'h60, 64'h1, 1'b1, 1'b1, 64'h48, 64'hCD, 64'h0);
    #3;
    checkOutput("after_ld_ack", ldAck, 1'b0);
    checkOutput("after_mem_addr", memAddr, 64'h60);
    checkOutput("after_cpu_stall", cpuStall, 1'b0);

    // Loader read with no CPU traffic; a CPU store arrives during the response
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0, 64'h0);
    #3;
    checkOutput("lr0_mem_read", memRead, 1'b1);
    checkOutput("lr0_mem_addr", memAddr, 64'h8);
    checkOutput("lr0_ld_ack", ldAck, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 64'h70, 64'h3, 1'b1, 1'b0, 64'h8, 64'h0, 64'h77);
    #3;
    checkOutput("lr1_ld_ack", ldAck, 1'b1);
    checkOutput("lr1_ld_rdata", ldRdata, 64'h77);
    checkOutput("lr1_mem_write", memWrite, 1'b0);
    checkOutput("lr1_cpu_stall", cpuStall, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 64'h70, 64'h3, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #3;
    checkOutput("lr2_ld_ack", ldAck, 1'b0);
    checkOutput("lr2_ld_rdata", ldRdata, 64'h77);
    checkOutput("lr2_mem_write", memWrite, 1'b1);
    checkOutput("lr2_mem_addr", memAddr, 64'h70);
    checkOutput("lr2_cpu_stall", cpuStall, 1'b0);

    // Reset in the middle of a loader response
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0, 64'h0);
    #3;
    checkOutput("rr0_mem_read", memRead, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0, 64'h55);
    #1;
    checkOutput("rr1_ld_ack_pre", ldAck, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rr1_ld_ack", ldAck, 1'b0);
    checkOutput("rr1_ld_rdata", ldRdata, 64'h0);
    checkOutput("rr1_cpu_rdata", cpuRdata, 64'h0);
    checkOutput("rr1_mem_read", memRead, 1'b0);
    nextCycle();
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rr2_mem_read", memRead, 1'b1);
    checkOutput("rr2_mem_addr", memAddr, 64'h18);
    checkOutput("rr2_ld_ack", ldAck, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0, 64'h66);
    #3;
    checkOutput("rr3_ld_ack", ldAck, 1'b1);
    checkOutput("rr3_ld_rdata", ldRdata, 64'h66);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #3;
    checkOutput("rr4_ld_ack", ldAck, 1'b0);
    checkOutput("rr4_ld_rdata", ldRdata, 64'h66);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive cycles a pending loader request may lose to the CPU before it is forced a grant.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_read, cpu_write  input  1 each  MEM-stage load/store request; held stable while cpu_stall=1.
REQ-005 cpu_addr, cpu_wdata  input  64 each  MEM-stage address (ALU result) and store data.
REQ-006 cpu_rdata  output  64  load data to the pipeline.
REQ-007 cpu_stall  output  1  freezes the pipeline while a CPU access is not yet complete.
REQ-008 ld_req, ld_we  input  1 each  loader/debug port request; ld_we=1 selects write; held until ld_ack.
REQ-009 ld_addr, ld_wdata  input  64 each  loader address and write data.
REQ-010 ld_ack  output  1  one-cycle pulse; the loader access is complete.
REQ-011 ld_rdata  output  64  loader read data; valid while ld_ack=1.
REQ-012 mem_addr, mem_wdata  output  64 each  data-memory address and write data.
REQ-013 mem_read, mem_write  output  1 each  data-memory strobes; at most one high per cycle.
REQ-014 mem_rdata  input  64  memory read data, valid the cycle after mem_read=1.

Function
REQ-015 FSM states: IDLE, CPU_RESP, LD_RESP; accesses are issued only in IDLE.
REQ-016 IDLE grant: loader wins if ld_req=1 and (no CPU request, or starve_cnt==STARVE_MAX); otherwise CPU wins if cpu_read|cpu_write.
REQ-017 Granted requester drives mem_addr/mem_wdata/mem_read/mem_write combinationally in the grant cycle; mem_* are 0 when nothing is issued.
REQ-018 cpu_read=1 and cpu_write=1 together: treated as write only; no read is issued.
REQ-019 CPU write: mem_write=1 in the grant cycle, cpu_stall=0 that cycle (1-cycle completion), FSM stays IDLE.
REQ-020 CPU read: mem_read=1 and cpu_stall=1 in the grant cycle; next state CPU_RESP.
REQ-021 CPU_RESP: cpu_rdata=mem_rdata, cpu_stall=0, mem strobes 0; the value is captured into a hold register; next state IDLE.
REQ-022 Outside CPU_RESP, cpu_rdata shows the hold register (last completed CPU read).
REQ-023 Loader write: mem_write=1 and ld_ack=1 in the grant cycle; FSM stays IDLE.
REQ-024 Loader read: mem_read=1 in the grant cycle, next state LD_RESP; in LD_RESP ld_ack=1, ld_rdata=mem_rdata (captured into hold), next IDLE.
REQ-025 cpu_stall=1 whenever a CPU request is present and not completing this cycle (lost arbitration, in LD_RESP, or read-issue cycle).
REQ-026 starve_cnt (3 bits): increments, saturating at STARVE_MAX, each IDLE cycle ld_req=1 while the CPU is granted; clears when the loader is granted or ld_req=0.
REQ-027 No request or back-to-back requests: a new access may issue in the IDLE cycle directly after a *_RESP cycle; no bubbles otherwise.
REQ-028 ld_ack never asserts without a loader grant; at most one ld_ack per loader request.

Reset
REQ-029 While reset=1: FSM=IDLE, starve_cnt=0, hold registers=0, cpu_rdata=0, ld_rdata=0, ld_ack=0, cpu_stall=0, all mem_* outputs=0.
REQ-030 Reset during CPU_RESP or LD_RESP abandons the access: no ld_ack, hold register not updated, requesters must re-request.

Verification
REQ-031 CPU load addr 0x10, mem_rdata=0xDEAD the next cycle -> cycle0 mem_read=1 cpu_stall=1; cycle1 cpu_rdata=0xDEAD cpu_stall=0; cycle2 onward cpu_rdata stays 0xDEAD.
REQ-032 CPU store 0x20 data 0x5 with ld_req idle -> mem_write=1, mem_addr=0x20, mem_wdata=0x5, cpu_stall=0 in the same cycle.
REQ-033 Loader write held while the CPU issues stores every cycle, STARVE_MAX=4 -> loader granted on the 5th cycle with ld_ack=1; cpu_stall=1 that cycle; starve_cnt returns to 0.
REQ-034 Loader read addr 0x8 with no CPU traffic, mem_rdata=0x77 -> LD_RESP next cycle: ld_ack=1, ld_rdata=0x77; exactly one ack pulse.
REQ-035 cpu_read=1 and cpu_write=1 simultaneously -> mem_write=1, mem_read=0, no stall.
REQ-036 Reset asserted mid-cycle in LD_RESP -> outputs go to 0 immediately, no ld_ack; after release, a re-issued loader read completes normally.
